axis_dest_demux: RTL
====================

# axis_dest_demux

AXI4-Stream packet demultiplexer: one input stream, M_COUNT output streams, routed per packet by the tdest value on the packet's first beat. It is the fan-out counterpart of the arbitrated mux. Each beat carries its own destination index through a registered skid stage, so back-to-back packets to different outputs pass without bubbles. Unroutable packets are consumed and discarded.

## Interface
- M_COUNT, 4, number of output streams (≥2)
- DATA_WIDTH, 8, tdata width
- KEEP_ENABLE, (DATA_WIDTH>8), propagate tkeep; else outputs all-ones
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width
- ID_ENABLE, 0, propagate tid; else outputs zero
- ID_WIDTH, 8, tid width
- DEST_WIDTH, $clog2(M_COUNT)+1, tdest width; must be ≥$clog2(M_COUNT)
- USER_ENABLE, 1, propagate tuser; else outputs zero
- USER_WIDTH, 1, tuser width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata/tkeep/tid/tdest/tuser  in  DATA/KEEP/ID/DEST/USER_WIDTH  input beat fields
- s_axis_tvalid, s_axis_tlast  in  1  input handshake/last
- s_axis_tready  out  1  registered ready
- m_axis_tdata/tkeep/tid/tuser  out  widths as above, shared by all outputs
- m_axis_tdest  out  DEST_WIDTH  original tdest of beat
- m_axis_tlast  out  1  shared by all outputs
- m_axis_tvalid  out  M_COUNT  one-hot; at most one bit set
- m_axis_tready  in  M_COUNT  per-output ready

## Operation
- Packet state: IDLE (next accepted beat is a first beat) and BODY (select latched).
- In IDLE, an accepted beat samples s_axis_tdest. A value < M_COUNT becomes sel_reg and the beat is forwarded. A value ≥ M_COUNT sets drop_reg and the beat is discarded.
- In BODY, beats use sel_reg/drop_reg. Mid-packet tdest changes are ignored.
- An accepted beat with tlast returns the FSM to IDLE and clears drop_reg. A single-beat packet stays in IDLE.
- Dropped beats are accepted at full rate and never reach the output stage.
- Output stage: skid pair (out reg + temp reg). Each entry holds {data, keep, last, id, dest, user, sel}.
- m_axis_tvalid = out_valid << out_sel.
- Effective ready = m_axis_tready[out_sel].
- s_axis_tready next = eff_ready || (!temp_valid && (!out_valid || !fwd_valid)), where fwd_valid = s_axis_tvalid && s_axis_tready && !drop.
- Moves: accept while out empty or eff_ready → into out. Accept while stalled → into temp. No accept and eff_ready → temp to out.

## Timing
- Reset (async assert, sync deassert assumed upstream): FSM=IDLE, drop_reg=0, sel_reg=0, out_valid=0, temp_valid=0, s_axis_tready=0. All m_axis_tvalid bits are 0. Data registers are don't-care.
- s_axis_tready rises the first clk after reset deasserts.
- Latency: input accept at edge N → m_axis_tvalid bit high after edge N, presented in cycle N+1.
- Throughput: 1 beat/cycle sustained, including a packet boundary to a different output.
- Stall: when the selected output deasserts ready, at most one extra beat lands in temp. s_axis_tready drops the following cycle.
- Holding ready low on a non-selected output never stalls traffic to another output once out/temp no longer hold beats for it.
- Reset mid-packet: in-flight beats are lost. The next beat after reset is treated as a first beat.

## Structure
- Shared package axis_pkg holds sel-width function clog2_safe (returns 1 for M_COUNT=1 guard) and the beat-record field-width constants.
- One sub-module, axis_skid_reg: two-entry register slice carrying the record plus sel. It is reusable by other stream blocks.
- The top holds the FSM, drop logic and the one-hot valid decode.

## Test plan
- Reset, then 3-beat packet tdest=2, tdata 0x11/0x22/0x33, all ready=1 → m_axis_tvalid=4'b0100 for 3 consecutive cycles starting 1 cycle after first accept. tlast on the 0x33 beat.
- Back-to-back single-beat packets tdest=0,1,3,0 → tvalid 0001,0010,1000,0001 on consecutive cycles with no bubble.
- Packet with tdest=5 (M_COUNT=4), 4 beats, followed by tdest=1 packet → no m_axis_tvalid during the drop. s_axis_tready stays 1. The tdest=1 packet emerges normally.
- Port 2 ready=0 for 5 cycles mid-packet → at most 2 beats buffered. s_axis_tready=0 from the cycle after stall plus 1. Data order is intact after release with no loss or duplication.
- tdest changed to 3 on beat 2 of a tdest=1 packet → all beats exit on port 1.
- rst_n asserted mid-packet at an arbitrary cycle (async) → all m_axis_tvalid=0 and s_axis_tready=0 immediately. After release, a new packet tdest=0 routes correctly.

Source files
------------

// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkg
// Brief    : Shared AXI4-Stream types, beat-record widths and sizing helpers.
// Revision : 1.0
// ============================================================================
package axis_pkg;

  typedef enum logic [0:0] {
    PKT_IDLE = 1'b0,
    PKT_BODY = 1'b1
  } pkt_state_t;

  localparam int c_last_width = 1;

  // Select width that never collapses to zero bits for a single output.
  function automatic int clog2_safe(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int beat_width(input int data_w, input int keep_w,
                                    input int id_w, input int dest_w,
                                    input int user_w);
    return data_w + keep_w + c_last_width + id_w + dest_w + user_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_reg.sv
`default_nettype none
// ============================================================================
// Module   : axis_skid_reg
// Brief    : Two-entry register slice (out + temp) carrying a payload and an
//            output select, with a registered upstream ready.
// Revision : 1.0
// ============================================================================
module axis_skid_reg #(
  parameter int WIDTH     = 8,
  parameter int SEL_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_WIDTH-1:0] in_sel,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel,
  input  logic                 out_ready
);

  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_temp_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic [WIDTH-1:0]     r_temp_data;
  logic [SEL_WIDTH-1:0] r_out_sel;
  logic [SEL_WIDTH-1:0] r_temp_sel;

  logic w_in_ready_next;
  logic w_out_valid_next;
  logic w_temp_valid_next;
  logic w_in_to_out;
  logic w_in_to_temp;
  logic w_temp_to_out;

  // in_valid is already qualified by the registered ready, so a beat is only
  // steered into temp when the output is held and the slot must be free.
  always_comb begin
    w_out_valid_next  = r_out_valid;
    w_temp_valid_next = r_temp_valid;
    w_in_to_out       = 1'b0;
    w_in_to_temp      = 1'b0;
    w_temp_to_out     = 1'b0;
    w_in_ready_next   = out_ready || (!r_temp_valid && (!r_out_valid || !in_valid));

    if (r_in_ready) begin
      if (out_ready || !r_out_valid) begin
        w_out_valid_next = in_valid;
        w_in_to_out      = 1'b1;
      end else begin
        w_temp_valid_next = in_valid;
        w_in_to_temp      = 1'b1;
      end
    end else if (out_ready) begin
      w_out_valid_next  = r_temp_valid;
      w_temp_valid_next = 1'b0;
      w_temp_to_out     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_temp_valid <= 1'b0;
      r_out_sel    <= '0;
      r_temp_sel   <= '0;
    end else begin
      r_in_ready   <= w_in_ready_next;
      r_out_valid  <= w_out_valid_next;
      r_temp_valid <= w_temp_valid_next;
      if (w_in_to_out) begin
        r_out_sel <= in_sel;
      end else if (w_temp_to_out) begin
        r_out_sel <= r_temp_sel;
      end
      if (w_in_to_temp) begin
        r_temp_sel <= in_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_to_out) begin
      r_out_data <= in_data;
    end else if (w_temp_to_out) begin
      r_out_data <= r_temp_data;
    end
    if (w_in_to_temp) begin
      r_temp_data <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: rtl/axis_dest_demux.sv
`default_nettype none
// ============================================================================
// Module   : axis_dest_demux
// Brief    : AXI4-Stream packet demux routed by the first-beat tdest;
//            unroutable packets are consumed and discarded.
// Revision : 1.0
// ============================================================================
module axis_dest_demux #(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_WIDTH  = $clog2(M_COUNT) + 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [M_COUNT-1:0]    m_axis_tvalid,
  input  logic [M_COUNT-1:0]    m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  import axis_pkg::*;

  localparam int c_sel_width = clog2_safe(M_COUNT);
  localparam int c_rec_width = beat_width(DATA_WIDTH, KEEP_WIDTH, ID_WIDTH,
                                          DEST_WIDTH, USER_WIDTH);
  localparam logic [DEST_WIDTH:0] c_m_count = (DEST_WIDTH + 1)'(M_COUNT);

  pkt_state_t             r_state;
  pkt_state_t             w_state_next;
  logic                   r_drop;
  logic                   w_drop_next;
  logic [c_sel_width-1:0] r_sel;
  logic [c_sel_width-1:0] w_sel_next;

  logic                   w_first;
  logic                   w_route_ok;
  logic                   w_drop;
  logic [c_sel_width-1:0] w_sel;
  logic                   w_accept;
  logic                   w_fwd_valid;
  logic                   w_s_ready;

  logic [KEEP_WIDTH-1:0]  w_keep;
  logic [ID_WIDTH-1:0]    w_id;
  logic [USER_WIDTH-1:0]  w_user;
  logic [c_rec_width-1:0] w_in_rec;
  logic [c_rec_width-1:0] w_out_rec;
  logic                   w_out_valid;
  logic [c_sel_width-1:0] w_out_sel;
  logic                   w_eff_ready;

  // Disabled sideband fields are forced to their fixed values before storage.
  assign w_keep = s_axis_tkeep | {KEEP_WIDTH{KEEP_ENABLE == 0}};
  assign w_id   = s_axis_tid   & {ID_WIDTH{ID_ENABLE != 0}};
  assign w_user = s_axis_tuser & {USER_WIDTH{USER_ENABLE != 0}};

  assign w_in_rec = {s_axis_tdata, w_keep, s_axis_tlast, w_id, s_axis_tdest, w_user};

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_sel_next   = r_sel;
    w_first      = (r_state == PKT_IDLE);
    w_route_ok   = ({1'b0, s_axis_tdest} < c_m_count);
    w_drop       = w_first ? !w_route_ok : r_drop;
    w_sel        = w_first ? s_axis_tdest[c_sel_width-1:0] : r_sel;
    w_accept     = s_axis_tvalid && w_s_ready;
    w_fwd_valid  = w_accept && !w_drop;

    if (w_accept) begin
      if (w_first && w_route_ok) begin
        w_sel_next = s_axis_tdest[c_sel_width-1:0];
      end
      if (s_axis_tlast) begin
        w_state_next = PKT_IDLE;
        w_drop_next  = 1'b0;
      end else if (w_first) begin
        w_state_next = PKT_BODY;
        w_drop_next  = !w_route_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PKT_IDLE;
      r_drop  <= 1'b0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
      r_sel   <= w_sel_next;
    end
  end

  // Each stored beat carries its own select, so a packet boundary to another
  // output needs no drain of the slice.
  axis_skid_reg #(
    .WIDTH     (c_rec_width),
    .SEL_WIDTH (c_sel_width)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w_fwd_valid),
    .in_data   (w_in_rec),
    .in_sel    (w_sel),
    .in_ready  (w_s_ready),
    .out_valid (w_out_valid),
    .out_data  (w_out_rec),
    .out_sel   (w_out_sel),
    .out_ready (w_eff_ready)
  );

  assign w_eff_ready   = m_axis_tready[w_out_sel];
  assign s_axis_tready = w_s_ready;
  assign m_axis_tvalid = {{(M_COUNT - 1){1'b0}}, w_out_valid} << w_out_sel;

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast,
          m_axis_tid, m_axis_tdest, m_axis_tuser} = w_out_rec;

endmodule
`default_nettype wire
